// File: rtl/eth_pkg.sv
// Shared types, constants and the bytewise CRC32 step for the Ethernet receive frame checker.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  // Byte enters bit 0 first into an MSB-out shift register; no reflection, no final XOR.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[31] ^ data[i]) ? ((c << 1) ^ CRC32_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered CRC32 accumulator with synchronous clear and byte enable.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o,
  output logic [31:0] crc_next_o
);

  logic [31:0] crc_q;

  assign crc_next_o = crc32_next(crc_q, data_i);
  assign crc_o      = crc_q;

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= CRC32_INIT;
    end else if (en_i) begin
      crc_q <= crc_next_o;
    end
  end

endmodule

// File: rtl/eth_rx_frame_check.sv
// Strips preamble/SFD and FCS, checks CRC and length, flags errors on the end-of-packet beat.
// Optional statistics counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_frame_check
  import eth_pkg::*;
#(
  parameter logic [31:0] P_RESIDUE = 32'hC704DD7B,
  parameter int unsigned P_MIN_LEN = 64,
  parameter int unsigned P_MAX_LEN = 1518
) (
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_error,
`ifdef ETH_RX_STATS_EN
  output logic [31:0] stat_good_cnt,
  output logic [31:0] stat_bad_cnt,
`endif
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_crc_err,
  output logic        out_len_err,
  output logic        out_phy_err,
  output logic [10:0] out_len
);

  state_e          state_q;
  logic [2:0]      pre_cnt_q;
  logic [10:0]     len_q;
  logic            phy_q;
  logic [2:0]      cnt_q;
  logic            emitted_q;
  logic [3:0][7:0] dl_q;

  logic [31:0] crc_q, crc_next;
  logic        crc_clr, crc_en;
  logic        is_pre, sop_pre, full;
  logic [10:0] len_inc;
  logic        len_bad;

  assign is_pre  = (in_data == PREAMBLE_BYTE);
  assign sop_pre = in_sop & is_pre;
  assign full    = (cnt_q == 3'd4);
  assign len_inc = (&len_q) ? len_q : len_q + 11'd1;
  assign len_bad = ({21'd0, len_inc} < P_MIN_LEN) || ({21'd0, len_inc} > P_MAX_LEN);

  assign crc_clr = in_valid && (state_q == PRE) && !in_eop && !is_pre && (in_data == SFD_BYTE);
  assign crc_en  = in_valid && (state_q == DATA) && !in_sop;

  eth_crc32 u_crc (
    .mac_clk    (mac_clk),
    .mac_rst_n  (mac_rst_n),
    .clr_i      (crc_clr),
    .en_i       (crc_en),
    .data_i     (in_data),
    .crc_o      (crc_q),
    .crc_next_o (crc_next)
  );

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      len_q       <= '0;
      phy_q       <= 1'b0;
      cnt_q       <= '0;
      emitted_q   <= 1'b0;
      dl_q        <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_crc_err <= 1'b0;
      out_len_err <= 1'b0;
      out_phy_err <= 1'b0;
      out_len     <= '0;
    end else begin
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_crc_err <= 1'b0;
      out_len_err <= 1'b0;
      out_phy_err <= 1'b0;
      out_len     <= '0;
      if (in_valid) begin
        unique case (state_q)
          IDLE: begin
            if (sop_pre) begin
              state_q   <= PRE;
              pre_cnt_q <= 3'd1;
            end
          end
          PRE: begin
            if (in_eop) begin
              state_q <= IDLE;
            end else if (is_pre) begin
              if (pre_cnt_q == 3'd7) state_q <= DROP;
              else pre_cnt_q <= pre_cnt_q + 3'd1;
            end else if (in_data == SFD_BYTE) begin
              state_q   <= DATA;
              len_q     <= '0;
              phy_q     <= 1'b0;
              cnt_q     <= '0;
              emitted_q <= 1'b0;
            end else begin
              state_q <= DROP;
            end
          end
          DATA: begin
            if (in_sop) begin
              // Abort: close the partial frame, then treat this byte as a fresh start.
              if (emitted_q) begin
                out_valid   <= 1'b1;
                out_eop     <= 1'b1;
                out_data    <= dl_q[3];
                out_crc_err <= (crc_q != P_RESIDUE);
                out_len_err <= 1'b1;
                out_phy_err <= phy_q;
                out_len     <= len_q;
              end
              state_q   <= sop_pre ? PRE : IDLE;
              pre_cnt_q <= 3'd1;
            end else begin
              len_q <= len_inc;
              phy_q <= phy_q | in_error;
              dl_q  <= {dl_q[2:0], in_data};
              if (!full) cnt_q <= cnt_q + 3'd1;
              if (in_eop) begin
                state_q <= IDLE;
                if (full) begin
                  out_valid   <= 1'b1;
                  out_sop     <= !emitted_q;
                  out_eop     <= 1'b1;
                  out_data    <= dl_q[3];
                  out_crc_err <= (crc_next != P_RESIDUE);
                  out_len_err <= len_bad;
                  out_phy_err <= phy_q | in_error;
                  out_len     <= len_inc;
                end
              end else if (full) begin
                out_valid <= 1'b1;
                out_sop   <= !emitted_q;
                out_data  <= dl_q[3];
                emitted_q <= 1'b1;
              end
            end
          end
          DROP: begin
            if (in_eop) begin
              state_q <= IDLE;
            end else if (sop_pre) begin
              state_q   <= PRE;
              pre_cnt_q <= 3'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef ETH_RX_STATS_EN
  logic drop_now, drop_q;

  // Frame ended before any byte could leave the delay line.
  assign drop_now = in_valid && (state_q == DATA) && !in_sop && in_eop && !full;

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      drop_q        <= 1'b0;
      stat_good_cnt <= '0;
      stat_bad_cnt  <= '0;
    end else begin
      drop_q <= drop_now;
      if (out_valid && out_eop) begin
        if (out_crc_err || out_len_err || out_phy_err) stat_bad_cnt <= stat_bad_cnt + 32'd1;
        else stat_good_cnt <= stat_good_cnt + 32'd1;
      end else if (drop_q) begin
        stat_bad_cnt <= stat_bad_cnt + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Randomized scoreboard bench for eth_rx_frame_check; expected beats come from a frame-level model.
module tb_eth_rx_frame_check;

  localparam logic [31:0] STD_RESIDUE = 32'h2144DF1C;

  logic        mac_clk, mac_rst_n;
  logic        in_sop, in_eop, in_valid, in_error;
  logic [7:0]  in_data;
  logic        out_sop, out_eop, out_valid;
  logic [7:0]  out_data;
  logic        out_crc_err, out_len_err, out_phy_err;
  logic [10:0] out_len;
`ifdef ETH_RX_STATS_EN
  logic [31:0] stat_good_cnt, stat_bad_cnt;
`endif

  eth_rx_frame_check dut (
    .mac_clk     (mac_clk),
    .mac_rst_n   (mac_rst_n),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_error    (in_error),
`ifdef ETH_RX_STATS_EN
    .stat_good_cnt (stat_good_cnt),
    .stat_bad_cnt  (stat_bad_cnt),
`endif
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_crc_err (out_crc_err),
    .out_len_err (out_len_err),
    .out_phy_err (out_phy_err),
    .out_len     (out_len)
  );

  initial mac_clk = 1'b0;
  always #5 mac_clk = ~mac_clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        crc;
    logic        lerr;
    logic        perr;
    logic [10:0] len;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pkt_q[$];
  int         err_at;
  int         checks, errors;
  int         exp_good, exp_bad;
  beat_t      mon_e, mon_g;

  // Standard Ethernet CRC32 (reflected, final XOR) over pkt_q[start:$].
  function automatic logic [31:0] std_crc(input int start);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = start; k < pkt_q.size(); k++) begin
      c = c ^ {24'd0, pkt_q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void build_frame(input int pre, input int plen, input bit rnd);
    logic [31:0] fcs;
    pkt_q.delete();
    err_at = -1;
    for (int k = 0; k < pre; k++) pkt_q.push_back(8'h55);
    pkt_q.push_back(8'hD5);
    for (int k = 0; k < plen; k++) pkt_q.push_back(rnd ? 8'($urandom) : 8'(k));
    fcs = std_crc(pre + 1);
    for (int k = 0; k < 4; k++) pkt_q.push_back(fcs[8*k +: 8]);
  endfunction

  // kind: 0 = ends with eop, 1 = cut by the next sop, 2 = cut by reset.
  function automatic void model_pkt(input int kind);
    int i, n;
    logic phy, crc_bad, lerr;
    logic [10:0] len;
    beat_t b;
    i = 0;
    while (i < pkt_q.size() && pkt_q[i] == 8'h55) i++;
    if (i < 1 || i > 7 || i >= pkt_q.size() || pkt_q[i] != 8'hD5) return;
    if (kind == 0 && i == pkt_q.size() - 1) return;
    i++;
    n       = pkt_q.size() - i;
    phy     = (err_at >= i);
    len     = (n > 2047) ? 11'd2047 : 11'(n);
    crc_bad = (std_crc(i) != STD_RESIDUE);
    lerr    = (n < 64) || (n > 1518);
    if (n <= 4) begin
      if (kind == 0) exp_bad++;
      return;
    end
    for (int k = 0; k < n - 4; k++) begin
      b = '0;
      b.data = pkt_q[i + k];
      b.sop  = (k == 0);
      if (kind == 0 && k == n - 5) begin
        b.eop = 1'b1; b.crc = crc_bad; b.lerr = lerr; b.perr = phy; b.len = len;
      end
      exp_q.push_back(b);
    end
    if (kind == 0) begin
      if (crc_bad || lerr || phy) exp_bad++;
      else exp_good++;
    end else if (kind == 1) begin
      b = '0;
      b.data = pkt_q[i + n - 4];
      b.eop = 1'b1; b.crc = crc_bad; b.lerr = 1'b1; b.perr = phy; b.len = len;
      exp_q.push_back(b);
      exp_bad++;
    end
  endfunction

  task automatic send(input bit has_eop, input int gap);
    for (int k = 0; k < pkt_q.size(); k++) begin
      @(negedge mac_clk);
      in_valid = 1'b1;
      in_data  = pkt_q[k];
      in_sop   = (k == 0);
      in_eop   = has_eop && (k == pkt_q.size() - 1);
      in_error = (k == err_at);
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        @(negedge mac_clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sop   = 1'($urandom);
        in_eop   = 1'($urandom);
        in_error = 1'($urandom);
      end
    end
    @(negedge mac_clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
  endtask

  task automatic run(input int kind, input int gap);
    model_pkt(kind);
    send(kind == 0, gap);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge mac_clk);
      t++;
    end
    chk("drain_pending_beats", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge mac_clk) begin
    if (mac_rst_n && out_valid) begin
      mon_g = {out_data, out_sop, out_eop, out_crc_err, out_len_err, out_phy_err, out_len};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%h sop=%b eop=%b", out_data, out_sop, out_eop);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_g.data !== mon_e.data || mon_g.sop !== mon_e.sop || mon_g.eop !== mon_e.eop ||
            (mon_e.eop && (mon_g.crc !== mon_e.crc || mon_g.lerr !== mon_e.lerr ||
                           mon_g.perr !== mon_e.perr || mon_g.len !== mon_e.len))) begin
          errors++;
          $display("FAIL beat got d=%h s=%b e=%b crc=%b len_err=%b phy=%b len=%0d exp d=%h s=%b e=%b crc=%b len_err=%b phy=%b len=%0d",
                   mon_g.data, mon_g.sop, mon_g.eop, mon_g.crc, mon_g.lerr, mon_g.perr, mon_g.len,
                   mon_e.data, mon_e.sop, mon_e.eop, mon_e.crc, mon_e.lerr, mon_e.perr, mon_e.len);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int r, pre, plen, cut;
    checks = 0; errors = 0; exp_good = 0; exp_bad = 0; err_at = -1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; in_data = '0;
    mac_rst_n = 1'b0;
    repeat (3) @(negedge mac_clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_sop", {31'd0, out_sop}, 0);
    chk("rst_out_eop", {31'd0, out_eop}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_flags", {29'd0, out_crc_err, out_len_err, out_phy_err}, 0);
    chk("rst_out_len", {21'd0, out_len}, 0);
    mac_rst_n = 1'b1;

    build_frame(7, 60, 1'b0); run(0, 0);                      // good 64-byte frame
    build_frame(7, 60, 1'b0); pkt_q[18] ^= 8'h01; run(0, 0);  // corrupt byte 10
    build_frame(7, 36, 1'b0); run(0, 0);                      // runt with valid FCS
    pkt_q.delete(); err_at = -1;                              // bad preamble
    pkt_q.push_back(8'h55); pkt_q.push_back(8'h55); pkt_q.push_back(8'h12);
    for (int k = 0; k < 70; k++) pkt_q.push_back(8'($urandom));
    run(0, 0);
    build_frame(7, 60, 1'b1); run(0, 0);
    build_frame(7, 60, 1'b1); err_at = 8 + 20; run(0, 1);     // phy error with gaps
    build_frame(7, 60, 1'b1); pkt_q = pkt_q[0:37]; run(1, 0); // abort after 30 bytes
    build_frame(7, 60, 1'b1); run(0, 0);
    build_frame(7, 3, 1'b1); pkt_q = pkt_q[0:10]; run(0, 0);  // 3-byte frame, dropped
    build_frame(7, 1, 1'b1); run(0, 0);                       // 5-byte frame: sop and eop together
    build_frame(7, 1600, 1'b1); run(0, 0);                    // oversize
    build_frame(2, 2100, 1'b1); run(0, 2);                    // length saturates
    build_frame(8, 60, 1'b1); run(0, 0);                      // 8 preamble bytes, dropped
    drain();

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      pre = $urandom_range(1, 8);
      plen = $urandom_range(0, 120);
      build_frame(pre, plen, 1'b1);
      if (r == 0) begin
        cut = pre + 1 + $urandom_range(1, 4);
        pkt_q = pkt_q[0:cut - 1];
        run(0, $urandom_range(0, 2));
      end else if (r == 1) begin
        pkt_q[1] = 8'($urandom_range(0, 8'h54));
        run(0, 0);
      end else if (r == 2) begin
        cut = pre + 1 + $urandom_range(1, plen + 3);
        pkt_q = pkt_q[0:cut - 1];
        run(1, $urandom_range(0, 2));
      end else begin
        if ($urandom_range(0, 9) < 3)
          pkt_q[pre + 1 + $urandom_range(0, plen + 3)] ^= 8'(1 << $urandom_range(0, 7));
        if ($urandom_range(0, 9) < 2) err_at = $urandom_range(0, pkt_q.size() - 1);
        run(0, $urandom_range(0, 2));
      end
    end
    build_frame(7, 64, 1'b1); run(0, 0);
    drain();

    // Reset mid-frame: beats already out are checked, the frame never completes.
    build_frame(7, 40, 1'b1); pkt_q = pkt_q[0:27];
    model_pkt(2); send(1'b0, 0);
    #2 mac_rst_n = 1'b0;
    #1 chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_out_data", {24'd0, out_data}, 0);
    chk("midrst_pending", exp_q.size(), 0);
    exp_q.delete(); exp_good = 0; exp_bad = 0;
    @(negedge mac_clk) mac_rst_n = 1'b1;
    build_frame(7, 60, 1'b0); run(0, 0);
    build_frame(7, 60, 1'b1); pkt_q = pkt_q[0:37]; run(1, 0);
    build_frame(7, 60, 1'b1); run(0, 1);
    drain();
    repeat (3) @(negedge mac_clk);
`ifdef ETH_RX_STATS_EN
    chk("stat_good_cnt", stat_good_cnt, exp_good);
    chk("stat_bad_cnt", stat_bad_cnt, exp_bad);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
